tia_hsync_counter_core: RTL and testbench
=========================================

Name: tia_hsync_counter_core

Overview:
- Horizontal timebase front end of the TIA.
- Divides the colour clock by 4 into two non-overlapping phase enables (hphi1/hphi2).
- Steps a 6-bit LFSR horizontal counter once per 4 clocks, with a 57-state period (228 colour clocks per line).
- Decodes seven fixed counter states into strobes used by the downstream horizontal timing logic (sync, blank, colour burst, centre).

Parameters:
- none (all counts are fixed by TIA line timing).

Ports:
- clk  input  1  colour clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state listed below.
- rsyn  input  1  synchronous RSYNC strobe, sampled on clk; restarts the divider and counter.
- hphi1  output  1  phase-1 enable; high 1 clk of every 4.
- hphi2  output  1  phase-2 enable; high 1 clk of every 4, two clks after hphi1.
- rsynl  output  1  latched RSYNC request.
- lfsr_out  output  6  LFSR counter state.
- shb  output  1  decode of state 010100 (count 56): end of line / set hblank.
- rsynd  output  1  rsynl delayed to the next phase-1 edge.
- shs  output  1  decode of 111100 (count 4): set hsync.
- rhs  output  1  decode of 110111 (count 8): reset hsync.
- rcb  output  1  decode of 001111 (count 12): reset colour burst.
- rhb  output  1  decode of 011100 (count 16): reset hblank.
- lrhb  output  1  decode of 010111 (count 18): late reset hblank (HMOVE).
- cnt  output  1  decode of 101100 (count 36): centre.

Behaviour:
- Phase ring:
  - 4-bit one-hot register, value 0001 on reset, rotates left each clk.
  - hphi1 = ring[1]; hphi2 = ring[3]. Both come straight from flops, so they never overlap.
  - After reset release: hphi1 is high in cycle 1, hphi2 in cycle 3, period 4.
- LFSR step:
  - Steps only on the clk edge that ends a cycle with hphi2 high.
  - Next state = {fb, out[5:1]}, where fb = ~(out[0] ^ out[1]).
  - If shb or rsynl is high at that edge, it loads 000000 instead of stepping.
  - Sequence from 000000: 100000, 110000, 111000, 111100, 111110, 011111, 101111, 110111, …, 010100 (count 56), then 000000.
  - Period is 57 steps = 228 clk.
- Decoder:
  - All seven strobes are purely combinational equality compares on lfsr_out.
  - Each is high for exactly the 4 clk in which lfsr_out holds its state.
  - At most one strobe is high at a time.
- rsyn handling:
  - rsyn sampled high forces ring to 0001 and sets rsynl = 1.
  - While rsyn stays high, the ring is held at 0001, so no phases and no LFSR steps occur.
  - rsynl clears on the hphi2 edge at which the LFSR loads 000000.
  - rsynd captures rsynl on every edge ending an hphi1 cycle.
  - rsyn coinciding with an hphi2 edge: rsyn wins; the ring restarts and the LFSR does not step on that edge.
- Reset values: ring = 0001, hphi1 = 0, hphi2 = 0, lfsr_out = 000000, rsynl = 0, rsynd = 0. Decode outputs follow lfsr_out, so all are 0.
- Reset is asserted and released asynchronously to clk; the first phase-1 pulse occurs 1 clk after release.
- Illegal LFSR state 111111 (unreachable) must still reach 000000 via rsyn.

Optional Feature:
- Macro TIA_HCOUNT_INDEX_EN.
- When defined: adds output hcount (6 bits), the binary index 0..56 of the current LFSR state.
  - Resets and loads 0 whenever the LFSR loads 000000.
  - Otherwise increments on every LFSR step.
- When not defined: port and logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then release -> hphi1 high in clk cycles 1, 5, 9, …; hphi2 high in cycles 3, 7, 11, …; never both high; lfsr_out = 000000.
- Free run for 8 hphi2 pulses -> lfsr_out = 100000, 110000, 111000, 111100 (shs = 1), 111110, 011111, 101111, 110111 (rhs = 1).
- Free run for one full line -> rcb at step 12, rhb at 16, lrhb at 18, cnt at 36, shb at 56 (010100); next step returns to 000000; shb recurs exactly 228 clk later.
- Pulse rsyn for 1 clk mid-line (e.g. at count 30) -> rsynl = 1; ring restarts (hphi1 1 clk later); lfsr_out = 000000 after the next hphi2; then rsynl = 0, and rsynd follows rsynl one phase-1 edge later.
- Hold rsyn high for 10 clk -> hphi1 and hphi2 stay 0 and lfsr_out is frozen; after release, normal phases resume and the counter restarts at 000000.
- Assert reset mid-line at count 40 -> all outputs return immediately to their reset values; with TIA_HCOUNT_INDEX_EN defined, hcount = 0 and then tracks 1..56 against the LFSR sequence.

Source files
------------

// File: rtl/tia_hsync_counter_core_if.sv
// ---------------------------------------------------------------------------
// tia_hsync_counter_core_if
//
// Purpose:
//   Bundles the RSYNC request and all horizontal timebase outputs of the TIA
//   horizontal counter front end. clk and reset are not part of the bundle.
//
// Signals:
//   rsyn      RSYNC strobe into the core (sampled on clk)
//   hphi1     phase-1 enable, one clk in four
//   hphi2     phase-2 enable, one clk in four, two clks after hphi1
//   rsynl     latched RSYNC request
//   rsynd     rsynl delayed to the next phase-1 edge
//   lfsr_out  6-bit LFSR horizontal counter state
//   shb, shs, rhs, rcb, rhb, lrhb, cnt
//             single-state decodes of lfsr_out
//   hcount    binary index 0..56 of lfsr_out (only with TIA_HCOUNT_INDEX_EN)
//
// Modports:
//   slave   the counter core (drives everything except rsyn)
//   master  the consumer / stimulus side (drives rsyn)
//
// Build option:
//   TIA_HCOUNT_INDEX_EN  adds the hcount signal to both modports.
// ---------------------------------------------------------------------------
interface tia_hsync_counter_core_if;
  logic       rsyn;
  logic       hphi1;
  logic       hphi2;
  logic       rsynl;
  logic       rsynd;
  logic [5:0] lfsr_out;
  logic       shb;
  logic       shs;
  logic       rhs;
  logic       rcb;
  logic       rhb;
  logic       lrhb;
  logic       cnt;
`ifdef TIA_HCOUNT_INDEX_EN
  logic [5:0] hcount;
`endif

  modport slave (
    input  rsyn,
    output hphi1,
    output hphi2,
    output rsynl,
    output rsynd,
    output lfsr_out,
    output shb,
    output shs,
    output rhs,
    output rcb,
    output rhb,
    output lrhb,
`ifdef TIA_HCOUNT_INDEX_EN
    output cnt,
    output hcount
`else
    output cnt
`endif
  );

  modport master (
    output rsyn,
    input  hphi1,
    input  hphi2,
    input  rsynl,
    input  rsynd,
    input  lfsr_out,
    input  shb,
    input  shs,
    input  rhs,
    input  rcb,
    input  rhb,
    input  lrhb,
`ifdef TIA_HCOUNT_INDEX_EN
    input  cnt,
    input  hcount
`else
    input  cnt
`endif
  );
endinterface

// File: rtl/tia_hsync_counter_core.sv
// ---------------------------------------------------------------------------
// tia_hsync_counter_core
//
// Purpose:
//   Horizontal timebase front end of the TIA. A 4-bit one-hot ring divides
//   the colour clock by four into two non-overlapping phase enables. A 6-bit
//   LFSR steps once per ring revolution and wraps after 57 states, giving the
//   228 colour clocks of one scan line. Seven fixed LFSR states are decoded
//   into strobes for the downstream horizontal timing logic.
//
// Ports:
//   clk    colour clock, all state changes on its rising edge
//   reset  asynchronous active-high reset
//   bus    tia_hsync_counter_core_if.slave
//            in : rsyn
//            out: hphi1, hphi2, rsynl, rsynd, lfsr_out,
//                 shb, shs, rhs, rcb, rhb, lrhb, cnt, [hcount]
//
// Build option:
//   TIA_HCOUNT_INDEX_EN  when defined, adds bus.hcount, the binary position
//                        (0..56) of the current LFSR state within the line.
// ---------------------------------------------------------------------------
module tia_hsync_counter_core (
  input logic                     clk,
  input logic                     reset,
  tia_hsync_counter_core_if.slave bus
);

  // Phase ring encodings. The ring only ever holds one of these four values.
  localparam logic [3:0] RING_IDLE = 4'b0001;
  localparam logic [3:0] RING_PH1  = 4'b0010;
  localparam logic [3:0] RING_GAP  = 4'b0100;
  localparam logic [3:0] RING_PH2  = 4'b1000;

  // Counter states that produce the horizontal strobes.
  localparam logic [5:0] LFSR_ZERO = 6'b000000;
  localparam logic [5:0] DEC_SHB   = 6'b010100;
  localparam logic [5:0] DEC_SHS   = 6'b111100;
  localparam logic [5:0] DEC_RHS   = 6'b110111;
  localparam logic [5:0] DEC_RCB   = 6'b001111;
  localparam logic [5:0] DEC_RHB   = 6'b011100;
  localparam logic [5:0] DEC_LRHB  = 6'b010111;
  localparam logic [5:0] DEC_CNT   = 6'b101100;

  logic [3:0] ring;
  logic [5:0] lfsr;
  logic [5:0] lfsr_next;
  logic       rsynl_q;
  logic       rsynd_q;
  logic       hphi1_edge;
  logic       hphi2_edge;
  logic       lfsr_load;
  logic       dec_shb;

  // The clock edge that closes a phase cycle is identified by the ring bit
  // that is currently high; an RSYNC on that same edge suppresses the step.
  assign hphi1_edge = (ring == RING_PH1);
  assign hphi2_edge = (ring == RING_PH2) && !bus.rsyn;

  // End of line and a pending RSYNC both restart the count from zero
  // instead of stepping.
  assign lfsr_load  = dec_shb || rsynl_q;

  // XNOR feedback keeps the all-zero state legal; 111111 is the lock-up
  // state of this polynomial and can only be left through RSYNC.
  assign lfsr_next  = {~(lfsr[0] ^ lfsr[1]), lfsr[5:1]};

  // Phase ring: rotates left every clock, RSYNC parks it at the idle
  // position so both phase enables stay low while RSYNC is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring <= RING_IDLE;
    end else if (bus.rsyn) begin
      ring <= RING_IDLE;
    end else begin
      unique case (ring)
        RING_IDLE: ring <= RING_PH1;
        RING_PH1:  ring <= RING_GAP;
        RING_GAP:  ring <= RING_PH2;
        RING_PH2:  ring <= RING_IDLE;
        default:   ring <= RING_IDLE;
      endcase
    end
  end

  // Horizontal counter: advances only at the end of a phase-2 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_ZERO;
    end else if (hphi2_edge) begin
      lfsr <= lfsr_load ? LFSR_ZERO : lfsr_next;
    end
  end

  // RSYNC latch: set by the raw strobe, cleared by the phase-2 edge that
  // performs the resulting counter restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsynl_q <= 1'b0;
    end else if (bus.rsyn) begin
      rsynl_q <= 1'b1;
    end else if (hphi2_edge && rsynl_q) begin
      rsynl_q <= 1'b0;
    end
  end

  // Delayed RSYNC: resampled at the end of every phase-1 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsynd_q <= 1'b0;
    end else if (hphi1_edge) begin
      rsynd_q <= rsynl_q;
    end
  end

`ifdef TIA_HCOUNT_INDEX_EN
  logic [5:0] hcount_q;

  // Binary shadow of the LFSR position, kept in lock-step with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= 6'd0;
    end else if (hphi2_edge) begin
      hcount_q <= lfsr_load ? 6'd0 : hcount_q + 6'd1;
    end
  end

  assign bus.hcount = hcount_q;
`else
  // Without the index option the LFSR state is the only position output.
`endif

  assign dec_shb      = (lfsr == DEC_SHB);

  assign bus.hphi1    = ring[1];
  assign bus.hphi2    = ring[3];
  assign bus.rsynl    = rsynl_q;
  assign bus.rsynd    = rsynd_q;
  assign bus.lfsr_out = lfsr;

  assign bus.shb      = dec_shb;
  assign bus.shs      = (lfsr == DEC_SHS);
  assign bus.rhs      = (lfsr == DEC_RHS);
  assign bus.rcb      = (lfsr == DEC_RCB);
  assign bus.rhb      = (lfsr == DEC_RHB);
  assign bus.lrhb     = (lfsr == DEC_LRHB);
  assign bus.cnt      = (lfsr == DEC_CNT);

endmodule

// File: tb/tb_tia_hsync_counter_core.sv
// ---------------------------------------------------------------------------
// tb_tia_hsync_counter_core
//
// Directed bench for the TIA horizontal counter front end. The expected LFSR
// line sequence is a hand-derived table; strobe expectations come from the
// position in that table, not from the state bits.
// Define TIA_HCOUNT_INDEX_EN to also check the hcount output.
// ---------------------------------------------------------------------------
module tb_tia_hsync_counter_core;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  int   cyc;

  tia_hsync_counter_core_if hif ();

  tia_hsync_counter_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  // One line of counter states, index = number of steps since 000000.
  logic [5:0] seq [57] = '{
    6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110,
    6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b011110,
    6'b001111, 6'b100111, 6'b110011, 6'b111001, 6'b011100, 6'b101110,
    6'b010111, 6'b101011, 6'b110101, 6'b011010, 6'b001101, 6'b000110,
    6'b000011, 6'b100001, 6'b010000, 6'b101000, 6'b110100, 6'b111010,
    6'b011101, 6'b001110, 6'b000111, 6'b100011, 6'b110001, 6'b011000,
    6'b101100, 6'b110110, 6'b011011, 6'b101101, 6'b010110, 6'b001011,
    6'b100101, 6'b010010, 6'b001001, 6'b000100, 6'b100010, 6'b010001,
    6'b001000, 6'b100100, 6'b110010, 6'b011001, 6'b001100, 6'b100110,
    6'b010011, 6'b101001, 6'b010100
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected strobe vector {shb,shs,rhs,rcb,rhb,lrhb,cnt} for a line position.
  function automatic logic [6:0] exp_strobes(input int idx);
    return {idx == 56, idx == 4, idx == 8, idx == 12, idx == 16, idx == 18, idx == 36};
  endfunction

  function automatic logic [6:0] act_strobes();
    return {hif.shb, hif.shs, hif.rhs, hif.rcb, hif.rhb, hif.lrhb, hif.cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    hif.rsyn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hif.lfsr_out !== 6'b000000) begin
      fails++;
      $display("[TB] FAIL reset_lfsr: got %b expected 000000", hif.lfsr_out);
    end
    checks++;
    if ({hif.hphi1, hif.hphi2} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_phases: got %b expected 00", {hif.hphi1, hif.hphi2});
    end
    checks++;
    if ({hif.rsynl, hif.rsynd} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_rsyn_flags: got %b expected 00", {hif.rsynl, hif.rsynd});
    end
    checks++;
    if (act_strobes() !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000000", act_strobes());
    end
`ifdef TIA_HCOUNT_INDEX_EN
    checks++;
    if (hif.hcount !== 6'd0) begin
      fails++;
      $display("[TB] FAIL reset_hcount: got %0d expected 0", hif.hcount);
    end
`endif
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_phases();
    logic e1, e2;
    repeat (12) begin
      tick();
      e1 = (cyc % 4 == 1);
      e2 = (cyc % 4 == 3);
      checks++;
      if ({hif.hphi1, hif.hphi2} !== {e1, e2}) begin
        fails++;
        $display("[TB] FAIL phases cyc%0d: got %b expected %b", cyc, {hif.hphi1, hif.hphi2}, {e1, e2});
      end
      checks++;
      if (hif.lfsr_out !== seq[cyc / 4]) begin
        fails++;
        $display("[TB] FAIL phase_lfsr cyc%0d: got %b expected %b", cyc, hif.lfsr_out, seq[cyc / 4]);
      end
    end
  endtask

  task automatic test_first_steps();
    int idx;
    while (cyc < 36) begin
      tick();
      idx = cyc / 4;
      checks++;
      if (hif.lfsr_out !== seq[idx]) begin
        fails++;
        $display("[TB] FAIL step_lfsr cyc%0d: got %b expected %b", cyc, hif.lfsr_out, seq[idx]);
      end
      checks++;
      if (act_strobes() !== exp_strobes(idx)) begin
        fails++;
        $display("[TB] FAIL step_strobes cyc%0d: got %b expected %b", cyc, act_strobes(), exp_strobes(idx));
      end
    end
  endtask

  task automatic test_full_line();
    int   idx;
    int   first_shb;
    int   second_shb;
    logic prev_shb;
    first_shb  = -1;
    second_shb = -1;
    prev_shb   = hif.shb;
    while (cyc < 460) begin
      tick();
      idx = (cyc / 4) % 57;
      checks++;
      if (hif.lfsr_out !== seq[idx]) begin
        fails++;
        $display("[TB] FAIL line_lfsr cyc%0d: got %b expected %b", cyc, hif.lfsr_out, seq[idx]);
      end
      checks++;
      if (act_strobes() !== exp_strobes(idx)) begin
        fails++;
        $display("[TB] FAIL line_strobes cyc%0d: got %b expected %b", cyc, act_strobes(), exp_strobes(idx));
      end
      checks++;
      if (hif.hphi1 && hif.hphi2) begin
        fails++;
        $display("[TB] FAIL phase_overlap cyc%0d: got 11 expected not both high", cyc);
      end
      if (hif.shb && !prev_shb) begin
        if (first_shb < 0) first_shb = cyc;
        else if (second_shb < 0) second_shb = cyc;
      end
      prev_shb = hif.shb;
    end
    checks++;
    if (first_shb !== 224) begin
      fails++;
      $display("[TB] FAIL shb_first: got cyc %0d expected cyc 224", first_shb);
    end
    checks++;
    if (second_shb - first_shb !== 228) begin
      fails++;
      $display("[TB] FAIL shb_period: got %0d expected 228", second_shb - first_shb);
    end
    checks++;
    if ({hif.rsynl, hif.rsynd} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL line_rsyn_flags: got %b expected 00", {hif.rsynl, hif.rsynd});
    end
  endtask

  task automatic test_rsyn_pulse();
    logic [5:0] el;
    while (cyc < 577) tick();
    checks++;
    if (hif.lfsr_out !== seq[30]) begin
      fails++;
      $display("[TB] FAIL pulse_precount: got %b expected %b", hif.lfsr_out, seq[30]);
    end
    hif.rsyn = 1'b1;
    tick();
    hif.rsyn = 1'b0;
    checks++;
    if ({hif.hphi1, hif.hphi2, hif.rsynl, hif.rsynd} !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL pulse_latch: got %b expected 0010",
               {hif.hphi1, hif.hphi2, hif.rsynl, hif.rsynd});
    end
    for (int r = 1; r <= 12; r++) begin
      tick();
      el = (r < 4) ? seq[30] : seq[r / 4 - 1];
      checks++;
      if ({hif.hphi1, hif.hphi2} !== {r % 4 == 1, r % 4 == 3}) begin
        fails++;
        $display("[TB] FAIL pulse_phases r%0d: got %b expected %b", r,
                 {hif.hphi1, hif.hphi2}, {r % 4 == 1, r % 4 == 3});
      end
      checks++;
      if (hif.lfsr_out !== el) begin
        fails++;
        $display("[TB] FAIL pulse_lfsr r%0d: got %b expected %b", r, hif.lfsr_out, el);
      end
      checks++;
      if ({hif.rsynl, hif.rsynd} !== {r < 4, r >= 2 && r <= 5}) begin
        fails++;
        $display("[TB] FAIL pulse_rsyn_flags r%0d: got %b expected %b", r,
                 {hif.rsynl, hif.rsynd}, {r < 4, r >= 2 && r <= 5});
      end
    end
  endtask

  task automatic test_rsyn_hold();
    logic [5:0] el;
    tick();
    hif.rsyn = 1'b1;
    repeat (10) begin
      tick();
      checks++;
      if ({hif.hphi1, hif.hphi2, hif.rsynl, hif.rsynd} !== 4'b0010) begin
        fails++;
        $display("[TB] FAIL hold_flags: got %b expected 0010",
                 {hif.hphi1, hif.hphi2, hif.rsynl, hif.rsynd});
      end
      checks++;
      if (hif.lfsr_out !== seq[2]) begin
        fails++;
        $display("[TB] FAIL hold_lfsr_frozen: got %b expected %b", hif.lfsr_out, seq[2]);
      end
    end
    hif.rsyn = 1'b0;
    for (int h = 1; h <= 12; h++) begin
      tick();
      el = (h < 4) ? seq[2] : seq[h / 4 - 1];
      checks++;
      if ({hif.hphi1, hif.hphi2} !== {h % 4 == 1, h % 4 == 3}) begin
        fails++;
        $display("[TB] FAIL hold_phases h%0d: got %b expected %b", h,
                 {hif.hphi1, hif.hphi2}, {h % 4 == 1, h % 4 == 3});
      end
      checks++;
      if (hif.lfsr_out !== el) begin
        fails++;
        $display("[TB] FAIL hold_lfsr h%0d: got %b expected %b", h, hif.lfsr_out, el);
      end
      checks++;
      if ({hif.rsynl, hif.rsynd} !== {h < 4, h >= 2 && h <= 5}) begin
        fails++;
        $display("[TB] FAIL hold_rsyn_flags h%0d: got %b expected %b", h,
                 {hif.rsynl, hif.rsynd}, {h < 4, h >= 2 && h <= 5});
      end
    end
  endtask

  task automatic test_rsyn_collision();
    repeat (3) tick();
    checks++;
    if (hif.hphi2 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL collide_setup_hphi2: got %b expected 1", hif.hphi2);
    end
    hif.rsyn = 1'b1;
    tick();
    hif.rsyn = 1'b0;
    checks++;
    if (hif.lfsr_out !== seq[2]) begin
      fails++;
      $display("[TB] FAIL collide_no_step: got %b expected %b", hif.lfsr_out, seq[2]);
    end
    checks++;
    if ({hif.hphi1, hif.hphi2, hif.rsynl} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL collide_flags: got %b expected 001", {hif.hphi1, hif.hphi2, hif.rsynl});
    end
    repeat (4) tick();
    checks++;
    if ({hif.lfsr_out, hif.rsynl} !== {seq[0], 1'b0}) begin
      fails++;
      $display("[TB] FAIL collide_restart: got %b expected %b", {hif.lfsr_out, hif.rsynl}, {seq[0], 1'b0});
    end
    repeat (4) tick();
    checks++;
    if (hif.lfsr_out !== seq[1]) begin
      fails++;
      $display("[TB] FAIL collide_resume: got %b expected %b", hif.lfsr_out, seq[1]);
    end
  endtask

  task automatic test_reset_midline();
    int idx;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 161) tick();
    checks++;
    if ({hif.lfsr_out, hif.hphi1, hif.cnt} !== {seq[40], 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL midline_setup: got %b expected %b", {hif.lfsr_out, hif.hphi1, hif.cnt},
               {seq[40], 1'b1, 1'b0});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({hif.lfsr_out, hif.hphi1, hif.hphi2, hif.rsynl, hif.rsynd, act_strobes()} !== 17'b0) begin
      fails++;
      $display("[TB] FAIL midline_async_reset: got %b expected all zero",
               {hif.lfsr_out, hif.hphi1, hif.hphi2, hif.rsynl, hif.rsynd, act_strobes()});
    end
`ifdef TIA_HCOUNT_INDEX_EN
    checks++;
    if (hif.hcount !== 6'd0) begin
      fails++;
      $display("[TB] FAIL midline_hcount_reset: got %0d expected 0", hif.hcount);
    end
`endif
    @(posedge clk);
    #3;
    reset = 1'b0;
    cyc   = 0;
    repeat (232) begin
      tick();
      idx = (cyc / 4) % 57;
      checks++;
      if ({hif.hphi1, hif.hphi2, hif.lfsr_out} !== {cyc % 4 == 1, cyc % 4 == 3, seq[idx]}) begin
        fails++;
        $display("[TB] FAIL midline_rerun cyc%0d: got %b expected %b", cyc,
                 {hif.hphi1, hif.hphi2, hif.lfsr_out}, {cyc % 4 == 1, cyc % 4 == 3, seq[idx]});
      end
`ifdef TIA_HCOUNT_INDEX_EN
      checks++;
      if (hif.hcount !== 6'(idx)) begin
        fails++;
        $display("[TB] FAIL hcount_track cyc%0d: got %0d expected %0d", cyc, hif.hcount, idx);
      end
`endif
    end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    cyc      = 0;
    reset    = 1'b1;
    hif.rsyn = 1'b0;
    $display("[TB] tia_hsync_counter_core directed test start");
    test_reset();
    test_phases();
    test_first_steps();
    test_full_line();
    test_rsyn_pulse();
    test_rsyn_hold();
    test_rsyn_collision();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
